clock_measure: RTL and testbench
================================

# clock_measure

Measures an incoming slow clock or periodic signal against the system clock. It reports the period and high time in `i_clk` cycles, flags loss of the signal, and indicates when the signal has settled to a steady frequency. It is the receive-side counterpart of the team's clock divider: it recovers the period of a divided or external clock (a divider with value D yields period 2·(D+1)). It sits between asynchronous clock inputs (LED-matrix pixel clock, external sync) and the control/CSR logic.

## Interface
- `IFREQ`, 96000000: `i_clk` frequency in Hz.
- `MIN_FREQ`, 1000: lowest measurable `i_sig` frequency in Hz; sets the timeout.
- `LOCK_COUNT`, 4: consecutive in-tolerance periods required to assert lock.
- `TOL`, 1: maximum allowed |period − previous period| for a period to count toward lock, in cycles.
- `i_clk`  in  1  system clock; all logic is in this domain.
- `i_reset`  in  1  asynchronous, active-high reset.
- `i_sig`  in  1  asynchronous signal under measurement.
- `o_period`  out  CNT_W  last complete rising-to-rising period, in `i_clk` cycles.
- `o_high`  out  CNT_W  high time of that period, rising-to-falling, in cycles.
- `o_valid`  out  1  one-cycle strobe when `o_period`/`o_high` update.
- `o_timeout`  out  1  level; no rising edge seen within TIMEOUT cycles.
- `o_locked`  out  1  level; frequency is stable.

CNT_W = $clog2(TIMEOUT+1). TIMEOUT = IFREQ / MIN_FREQ.

## Operation
- **Synchronisation:** `i_sig` passes through a 2-flop synchroniser, then a registered edge detector produces single-cycle `rise`/`fall` pulses.
- **States:** WAIT_FIRST, MEASURE.
  - Reset enters WAIT_FIRST.
  - WAIT_FIRST on `rise`: the counter loads 1, and the state goes to MEASURE. No `o_valid` is produced.
  - MEASURE: the counter increments every cycle.
    - On `fall`, the current count is captured into the high-time register.
    - On `rise`:
      - `o_period` ← count.
      - `o_high` ← captured high time.
      - `o_valid` pulses.
      - The counter reloads 1.
  - MEASURE timeout: when the count reaches TIMEOUT without a `rise`:
    - `o_timeout` ← 1.
    - `o_locked` ← 0.
    - The lock counter is cleared.
    - The state goes to WAIT_FIRST.
    - `o_period`/`o_high` keep their last values.
- **Clearing timeout:** `o_timeout` clears on the next `rise`, i.e. the edge that leaves WAIT_FIRST.
- **No fall in a period:** if no `fall` is seen within a period, `o_high` reports the last captured value.
- **Lock:**
  - On each `o_valid`, the new period is compared with the previous `o_period`.
  - If |diff| ≤ TOL, the lock counter increments, saturating at LOCK_COUNT. Otherwise it resets to 0 and `o_locked` ← 0.
  - `o_locked` ← 1 when the lock counter reaches LOCK_COUNT.
  - The first period after WAIT_FIRST is never compared, because there is no valid previous period.
- **Counter limit:** the counter saturates at TIMEOUT and never wraps.
- **Simultaneous `rise` and timeout:** `rise` wins. The period is reported as TIMEOUT and `o_timeout` stays 0.

## Timing
- **Reset values:** all outputs 0; state WAIT_FIRST; counters 0.
- **Input latency:** a transition on `i_sig` reaches `rise`/`fall` 3 `i_clk` cycles later (2 synchroniser stages + 1 edge register).
- **Output latency:** `o_valid`, `o_period` and `o_high` are registered. They update in the cycle after `rise`.
- **Lock latency:** `o_locked` updates in the same cycle as the `o_valid` that completes lock.
- **Measurement accuracy:** ±1 cycle, from synchroniser phase.
- **Narrow pulses:** highs or lows shorter than 1 `i_clk` cycle may be missed.
- **Timeout timing:** `o_timeout` asserts on the cycle the count hits TIMEOUT.
- **Reset mid-measurement:** reset takes effect immediately and asynchronously. Partial counts are discarded and the first edge after reset is not measured.

## Structure
- Shared package `clock_pkg`:
  - holds the state enum (WAIT_FIRST, MEASURE) and the CNT_W/TIMEOUT computation function;
  - is reused by the clock divider for DIV_VALUE sizing.
- Sub-module `sync_edge`:
  - 2-flop synchroniser plus rise/fall pulse generation;
  - parameter-free, one bit;
  - reusable for button and sync inputs.
- The top level holds the FSM, period/high counters, and lock logic.

## Test plan
- **Steady square wave:** IFREQ=96e6, `i_sig` toggles every 3 `i_clk` cycles (divider D=2) → `o_valid` every 6 cycles with `o_period`=6 and `o_high`=3 (±1 on the first valid). `o_locked`=1 after the 5th `o_valid` (first period uncompared, then 4 matches).
- **Duty cycle:** high 5 cycles, low 11 cycles → `o_period`=16, `o_high`=5.
- **Frequency step:** period 6 for 10 periods, then period 10 → `o_locked` drops on the first `o_valid` with `o_period`=10, and reasserts 4 periods later.
- **Signal loss:** `i_sig` held low with TIMEOUT=1000 (MIN_FREQ=96000) → `o_timeout`=1 exactly 1000 cycles after the last measured rise, `o_locked`=0, and `o_period` unchanged. The next two rises 8 cycles apart → `o_timeout` clears on the first rise and `o_valid` fires with `o_period`=8.
- **Reset mid-period:** `i_reset` pulsed during MEASURE → all outputs 0 immediately. The first rise after release produces no `o_valid`; the second produces the correct period.
- **Jitter tolerance:** periods alternating 6/7 with TOL=1 → lock holds. Periods alternating 6/8 → never locks.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared clock-domain helpers: FSM state and
// counter sizing for the divider/measure pair.
package clock_pkg;

   typedef enum logic {
      WAIT_FIRST = 1'b0,
      MEASURE    = 1'b1
   } state_t;

   function automatic int timeout_cycles(
      input int ifreq,
      input int min_freq
   );
      return ifreq / min_freq;
   endfunction

   function automatic int cnt_width(
      input int timeout
   );
      return $clog2(timeout + 1);
   endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser for one async bit with
// registered single-cycle rise/fall pulses.
module sync_edge (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_sig,
   output logic o_rise,
   output logic o_fall
);

   logic [2:0] sync_q;

   // shift the input through two sync stages plus a history bit
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         sync_q <= '0;
         o_rise <= 1'b0;
         o_fall <= 1'b0;
      end else begin
         sync_q <= {sync_q[1:0], i_sig};
         o_rise <= sync_q[1] & ~sync_q[2];
         o_fall <= ~sync_q[1] & sync_q[2];
      end
   end

endmodule

// File: rtl/clock_measure.sv
// Measures period/high time of a slow async signal
// in i_clk cycles, with loss and lock detection.
module clock_measure
   import clock_pkg::*;
#(
   parameter  int IFREQ      = 96000000,
   parameter  int MIN_FREQ   = 1000,
   parameter  int LOCK_COUNT = 4,
   parameter  int TOL        = 1,
   localparam int TIMEOUT    = timeout_cycles(IFREQ, MIN_FREQ),
   localparam int CNT_W      = cnt_width(TIMEOUT)
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_sig,
   output logic [CNT_W-1:0] o_period,
   output logic [CNT_W-1:0] o_high,
   output logic             o_valid,
   output logic             o_timeout,
   output logic             o_locked
);

   localparam int LK_W = $clog2(LOCK_COUNT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] TOL_C   = CNT_W'(TOL);
   localparam logic [LK_W-1:0]  LK_MAX  = LK_W'(LOCK_COUNT);

   logic             rise;
   logic             fall;
   state_t           state_q;
   state_t           state_d;
   logic             load;
   logic             report;
   logic             expire;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] high_cap_q;
   logic [CNT_W-1:0] diff;
   logic [LK_W-1:0]  lock_q;
   logic [LK_W-1:0]  lock_inc;
   logic             has_prev_q;

   sync_edge u_sync (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_sig   (i_sig),
      .o_rise  (rise),
      .o_fall  (fall)
   );

   // state register
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) state_q <= WAIT_FIRST;
      else         state_q <= state_d;
   end

   // next state; a rise beats a same-cycle timeout
   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      report  = 1'b0;
      expire  = 1'b0;
      unique case (state_q)
         WAIT_FIRST: begin
            if (rise) begin
               state_d = MEASURE;
               load    = 1'b1;
            end
         end
         MEASURE: begin
            if (rise) begin
               load   = 1'b1;
               report = 1'b1;
            end else if (cnt_q == CNT_MAX) begin
               expire  = 1'b1;
               state_d = WAIT_FIRST;
            end
         end
      endcase
   end

   // period distance to the previous result and next lock count
   always_comb begin
      diff     = (cnt_q >= o_period) ? cnt_q - o_period
                                     : o_period - cnt_q;
      lock_inc = (lock_q == LK_MAX) ? lock_q
                                    : lock_q + LK_W'(1);
   end

   // saturating period counter and high-time capture
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         cnt_q      <= '0;
         high_cap_q <= '0;
      end else begin
         if (load)
            cnt_q <= CNT_W'(1);
         else if (state_q == MEASURE && cnt_q != CNT_MAX)
            cnt_q <= cnt_q + CNT_W'(1);
         if (state_q == MEASURE && fall)
            high_cap_q <= cnt_q;
      end
   end

   // registered results and loss flag
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         o_period  <= '0;
         o_high    <= '0;
         o_valid   <= 1'b0;
         o_timeout <= 1'b0;
      end else begin
         o_valid <= report;
         if (report) begin
            o_period <= cnt_q;
            o_high   <= high_cap_q;
         end
         if (expire)    o_timeout <= 1'b1;
         else if (load) o_timeout <= 1'b0;
      end
   end

   // lock tracking; first period after a restart has no reference
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         lock_q     <= '0;
         o_locked   <= 1'b0;
         has_prev_q <= 1'b0;
      end else if (expire) begin
         lock_q     <= '0;
         o_locked   <= 1'b0;
         has_prev_q <= 1'b0;
      end else if (report) begin
         if (!has_prev_q) begin
            has_prev_q <= 1'b1;
         end else if (diff <= TOL_C) begin
            lock_q <= lock_inc;
            if (lock_inc == LK_MAX) o_locked <= 1'b1;
         end else begin
            lock_q   <= '0;
            o_locked <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_clock_measure.sv
// Directed bench for clock_measure with TIMEOUT=1000:
// waveform table plus loss, boundary and reset sequences.
module tb_clock_measure;

   localparam int W = 10;

   logic         clk;
   logic         i_reset;
   logic         i_sig;
   logic [W-1:0] o_period;
   logic [W-1:0] o_high;
   logic         o_valid;
   logic         o_timeout;
   logic         o_locked;

   int checks   = 0;
   int failures = 0;

   int vp [256];
   int vh [256];
   int vl [256];
   int nvalid  = 0;
   int cyc     = 0;
   int tv_last = 0;
   int tt_rise = 0;
   int n_to    = 0;
   logic to_prev = 1'b0;

   clock_measure #(
      .IFREQ      (96000000),
      .MIN_FREQ   (96000),
      .LOCK_COUNT (4),
      .TOL        (1)
   ) dut (
      .i_clk     (clk),
      .i_reset   (i_reset),
      .i_sig     (i_sig),
      .o_period  (o_period),
      .o_high    (o_high),
      .o_valid   (o_valid),
      .o_timeout (o_timeout),
      .o_locked  (o_locked)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // record every strobe and timeout onset at the falling edge
   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (o_valid && nvalid < 256) begin
         vp[nvalid] <= int'(o_period);
         vh[nvalid] <= int'(o_high);
         vl[nvalid] <= int'(o_locked);
         nvalid     <= nvalid + 1;
         tv_last    <= cyc;
      end
      if (o_timeout && !to_prev) begin
         n_to    <= n_to + 1;
         tt_rise <= cyc;
      end
      to_prev <= o_timeout;
   end

   typedef struct {
      int hi;
      int lo;
      int reps;
      int e_per;
      int e_high;
      int e_lock;
      int e_nv;
   } vec_t;

   vec_t tbl [4];
   int   rbase [4];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int hi, input int lo);
      i_sig = 1'b1;
      repeat (hi) tick();
      i_sig = 1'b0;
      repeat (lo) tick();
   endtask

   task automatic check(input string name, input int act,
                        input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d",
                  name, act, exp);
      end
   endtask

   initial begin
      int b;
      int cnt;
      int nv0;

      i_reset = 1'b1;
      i_sig   = 1'b0;
      repeat (3) tick();
      check("rst_period",  int'(o_period),  0);
      check("rst_high",    int'(o_high),    0);
      check("rst_valid",   int'(o_valid),   0);
      check("rst_timeout", int'(o_timeout), 0);
      check("rst_locked",  int'(o_locked),  0);
      i_reset = 1'b0;
      repeat (2) tick();

      // hi, lo, reps, period, high, locked, valids
      tbl[0] = '{3, 3,  8,  6, 3, 1,  7};
      tbl[1] = '{5, 11, 4, 16, 5, 0,  4};
      tbl[2] = '{3, 3, 10,  6, 3, 1, 10};
      tbl[3] = '{5, 5,  6, 10, 5, 1,  6};

      for (int r = 0; r < 4; r++) begin
         rbase[r] = nvalid;
         repeat (tbl[r].reps) drive(tbl[r].hi, tbl[r].lo);
         check($sformatf("row%0d_period", r),
               int'(o_period), tbl[r].e_per);
         check($sformatf("row%0d_high", r),
               int'(o_high), tbl[r].e_high);
         check($sformatf("row%0d_locked", r),
               int'(o_locked), tbl[r].e_lock);
         check($sformatf("row%0d_nvalid", r),
               nvalid - rbase[r], tbl[r].e_nv);
      end

      b = rbase[0];
      check("steady_first_period", vp[b], 6);
      check("steady_lock_4th", vl[b + 3], 0);
      check("steady_lock_5th", vl[b + 4], 1);

      b = rbase[3];
      check("step_first10_period", vp[b + 1], 10);
      check("step_first10_unlock", vl[b + 1], 0);
      check("step_relock_early",   vl[b + 4], 0);
      check("step_relock",         vl[b + 5], 1);

      // alternating 6/7 stays within tolerance
      b = nvalid;
      for (int i = 0; i < 8; i++) begin
         drive(3, 3);
         drive(3, 4);
      end
      check("jit67_nvalid", nvalid - b, 16);
      check("jit67_unlock", vl[b + 4], 0);
      cnt = 0;
      for (int i = 5; i < 16; i++)
         if (vl[b + i] != 1) cnt++;
      check("jit67_hold_drops", cnt, 0);
      check("jit67_p7", vp[b + 2], 7);

      // alternating 6/8 never locks
      b = nvalid;
      for (int i = 0; i < 6; i++) begin
         drive(3, 3);
         drive(3, 5);
      end
      check("jit68_nvalid", nvalid - b, 12);
      cnt = 0;
      for (int i = 2; i < 12; i++)
         if (vl[b + i] != 0) cnt++;
      check("jit68_locks", cnt, 0);
      check("jit68_p8", vp[b + 2], 8);

      // signal loss with input held low
      for (int i = 0; i < 1100 && !o_timeout; i++) tick();
      check("loss_timeout", int'(o_timeout), 1);
      tick();
      check("loss_delay", tt_rise - tv_last, 1000);
      check("loss_count", n_to, 1);
      check("loss_locked", int'(o_locked), 0);
      check("loss_period", int'(o_period), 6);

      // recovery, then a period of exactly TIMEOUT
      nv0 = nvalid;
      drive(4, 4);
      check("rec_timeout_clr", int'(o_timeout), 0);
      check("rec_no_valid", nvalid - nv0, 0);
      drive(4, 996);
      check("rec_nvalid", nvalid - nv0, 1);
      check("rec_period8", vp[nvalid - 1], 8);
      check("rec_high8", vh[nvalid - 1], 4);
      check("edge_no_to_early", int'(o_timeout), 0);
      drive(4, 4);
      check("edge_period", int'(o_period), 1000);
      check("edge_timeout", int'(o_timeout), 0);
      check("edge_to_count", n_to, 1);

      // asynchronous reset in the middle of a period
      repeat (3) drive(3, 3);
      repeat (2) tick();
      check("pre_rst_period", int'(o_period), 6);
      @(posedge clk);
      #3;
      i_reset = 1'b1;
      #1;
      check("mid_rst_period",  int'(o_period),  0);
      check("mid_rst_high",    int'(o_high),    0);
      check("mid_rst_valid",   int'(o_valid),   0);
      check("mid_rst_timeout", int'(o_timeout), 0);
      check("mid_rst_locked",  int'(o_locked),  0);
      @(posedge clk);
      #1;
      i_reset = 1'b0;
      repeat (3) tick();
      nv0 = nvalid;
      drive(3, 3);
      check("post_rst_first", nvalid - nv0, 0);
      drive(3, 4);
      check("post_rst_second", nvalid - nv0, 1);
      check("post_rst_period", int'(o_period), 6);
      check("post_rst_high", int'(o_high), 3);
      check("post_rst_locked", int'(o_locked), 0);

      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end

endmodule
